// File: rtl/axis_cfg_seq_pkg.sv
// Shared definitions for the config-bus sequencer: FSM state encoding and
// transfer-direction constants.
package axis_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    ADDR = 3'd2,
    LEN  = 3'd3,
    GAP  = 3'd4
  } seq_state_e;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/axis_cfg_seq_if.sv
// Command handshake plus config-bus bundle between a command issuer (master)
// and the sequencer (slave).
interface axis_cfg_seq_if #(
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic [CFG_DWIDTH-1:0] cmd_addr;
  logic [CFG_DWIDTH-1:0] cmd_len;
  logic [CFG_AWIDTH-1:0] cfg_addr;
  logic [CFG_DWIDTH-1:0] cfg_data;
  logic                  cfg_valid;
  logic                  busy;
  logic [15:0]           cmd_count;

  modport master (
    output cmd_valid, cmd_dir, cmd_addr, cmd_len,
    input  cmd_ready, cfg_addr, cfg_data, cfg_valid, busy, cmd_count
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_addr, cmd_len,
    output cmd_ready, cfg_addr, cfg_data, cfg_valid, busy, cmd_count
  );

endinterface

// File: rtl/axis_cfg_seq_gap.sv
// Post-command idle-gap down-counter; only instantiated when
// AXIS_CFG_SEQ_GAP_EN is defined. last_o marks the final GAP cycle.
module axis_cfg_seq_gap #(
  parameter int GAP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic last_o
);

  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  logic [GW-1:0] cnt_q;
  logic [GW-1:0] cnt_d;

  // Load on the LEN beat, count down to zero while in GAP.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = GW'(GAP_CYCLES);
    end else if (en_i && (cnt_q != {GW{1'b0}})) begin
      cnt_d = cnt_q - GW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {GW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load of 0 still gives one GAP cycle, hence "<= 1".
  assign last_o = (cnt_q <= GW'(1));

endmodule

// File: rtl/axis_cfg_seq.sv
// Turns one accepted command into three back-to-back config beats
// (path select, start address, length). Optional macro AXIS_CFG_SEQ_GAP_EN
// adds an idle GAP state of GAP_CYCLES cycles after each command.
module axis_cfg_seq
  import axis_pkg::*;
#(
  parameter int CFG_ID_WR  = 1,
  parameter int CFG_ID_RD  = 2,
  parameter int CFG_ADDR   = 23,
  parameter int CFG_DATA   = 24,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32,
  parameter int GAP_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  axis_cfg_seq_if.slave bus
);

  localparam logic [CFG_AWIDTH-1:0] ID_WR_C = CFG_AWIDTH'(CFG_ID_WR);
  localparam logic [CFG_AWIDTH-1:0] ID_RD_C = CFG_AWIDTH'(CFG_ID_RD);
  localparam logic [CFG_AWIDTH-1:0] ADDR_C  = CFG_AWIDTH'(CFG_ADDR);
  localparam logic [CFG_AWIDTH-1:0] DATA_C  = CFG_AWIDTH'(CFG_DATA);

  seq_state_e            state_q;
  logic [CFG_DWIDTH-1:0] addr_q;
  logic [CFG_DWIDTH-1:0] len_q;
  logic                  cmd_ready_q;
  logic                  busy_q;
  logic                  cfg_valid_q;
  logic [CFG_AWIDTH-1:0] cfg_addr_q;
  logic [CFG_DWIDTH-1:0] cfg_data_q;
  logic [CNT_WIDTH-1:0]  cmd_count_q;

`ifdef AXIS_CFG_SEQ_GAP_EN
  logic gap_last_s;

  axis_cfg_seq_gap #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == LEN),
    .en_i   (state_q == GAP),
    .last_o (gap_last_s)
  );
`else
  // GAP_CYCLES has no effect without the gap stage.
  logic unused_gap_s;
  assign unused_gap_s = (GAP_CYCLES != 0);
`endif

  // Sequencer FSM; outputs are set on the edge entering each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= {CFG_DWIDTH{1'b0}};
      len_q       <= {CFG_DWIDTH{1'b0}};
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= {CFG_AWIDTH{1'b0}};
      cfg_data_q  <= {CFG_DWIDTH{1'b0}};
      cmd_count_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            addr_q <= bus.cmd_addr;
            len_q  <= bus.cmd_len;
            // Zero-length commands are consumed without any beats.
            if (bus.cmd_len != {CFG_DWIDTH{1'b0}}) begin
              state_q     <= SEL;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              cfg_valid_q <= 1'b1;
              cfg_addr_q  <= (bus.cmd_dir == DIR_RD) ? ID_RD_C : ID_WR_C;
              cfg_data_q  <= {CFG_DWIDTH{1'b0}};
            end
          end
        end
        SEL: begin
          state_q    <= ADDR;
          cfg_addr_q <= ADDR_C;
          cfg_data_q <= addr_q;
        end
        ADDR: begin
          state_q     <= LEN;
          cfg_addr_q  <= DATA_C;
          cfg_data_q  <= len_q;
          cmd_count_q <= cmd_count_q + 16'd1;
        end
        LEN: begin
          cfg_valid_q <= 1'b0;
          cfg_addr_q  <= {CFG_AWIDTH{1'b0}};
          cfg_data_q  <= {CFG_DWIDTH{1'b0}};
`ifdef AXIS_CFG_SEQ_GAP_EN
          state_q     <= GAP;
`else
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
`endif
        end
`ifdef AXIS_CFG_SEQ_GAP_EN
        GAP: begin
          if (gap_last_s) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          cfg_valid_q <= 1'b0;
          cfg_addr_q  <= {CFG_AWIDTH{1'b0}};
          cfg_data_q  <= {CFG_DWIDTH{1'b0}};
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.cfg_addr  = cfg_addr_q;
  assign bus.cfg_data  = cfg_data_q;
  assign bus.cmd_count = cmd_count_q;

endmodule

// File: doc/axis_cfg_seq.md
AXIS_CFG_SEQ -- requirements
Module: axis_cfg_seq

Interface
REQ-001 SHALL have parameter CFG_ID_WR, default 1: path-select code for the write path.
REQ-002 SHALL have parameter CFG_ID_RD, default 2: path-select code for the read path.
REQ-003 SHALL have parameter CFG_ADDR, default 23: config address of the start-address register.
REQ-004 SHALL have parameter CFG_DATA, default 24: config address of the transfer-length register.
REQ-005 SHALL have parameter CFG_AWIDTH, default 5: config address width.
REQ-006 SHALL have parameter CFG_DWIDTH, default 32: config data, command address and command length width.
REQ-007 SHALL have parameter GAP_CYCLES, default 4: idle cycles after each command, used only with AXIS_CFG_SEQ_GAP_EN.
REQ-008 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-010 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1): the command handshake.
REQ-011 SHALL have port cmd_dir, input, 1: transfer direction, 0 = write path, 1 = read path.
REQ-012 SHALL have ports cmd_addr and cmd_len, each input, CFG_DWIDTH: start byte address and length.
REQ-013 SHALL have ports cfg_addr (output, CFG_AWIDTH), cfg_data (output, CFG_DWIDTH) and cfg_valid (output, 1): the config bus to the axis block.
REQ-014 SHALL have port busy, output, 1: high whenever the block is not in IDLE.
REQ-015 SHALL have port cmd_count, output, 16: number of commands issued.

Function
REQ-016 SHALL implement the states IDLE, SEL, ADDR, LEN and GAP.
REQ-017 SHALL drive cmd_ready high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high, and its fields are captured in registers.
REQ-018 SHALL move from IDLE to SEL on an accepted command with cmd_len != 0.
REQ-019 SHALL stay in IDLE on an accepted command with cmd_len == 0: command dropped, no cfg beats, cmd_count unchanged.
REQ-020 SHALL, in SEL, drive cfg_valid=1, cfg_addr=(cmd_dir ? CFG_ID_RD : CFG_ID_WR) and cfg_data=0 for exactly one cycle, then go to ADDR.
REQ-021 SHALL, in ADDR, drive cfg_valid=1, cfg_addr=CFG_ADDR and cfg_data=captured address for one cycle, then go to LEN.
REQ-022 SHALL, in LEN, drive cfg_valid=1, cfg_addr=CFG_DATA and cfg_data=captured length for one cycle, then go to GAP (macro defined) or IDLE (macro not defined).
REQ-023 SHALL register all outputs, so the first cfg beat appears one cycle after acceptance; the three beats are back-to-back, with no backpressure on the config bus.
REQ-024 SHALL drive cfg_valid=0, cfg_addr=0 and cfg_data=0 in IDLE and GAP.
REQ-025 SHALL increment cmd_count on the LEN beat, wrapping from 0xFFFF to 0x0000.
REQ-026 SHALL hold cmd_ready low from the acceptance cycle until IDLE is re-entered; minimum command spacing is 4 cycles without the gap and 4+GAP_CYCLES cycles with it.

Reset
REQ-027 SHALL, on rst, go to IDLE and set cfg_valid=0, cfg_addr=0, cfg_data=0, busy=0, cmd_count=0, the gap counter to 0 and cmd_ready=1 from the next cycle.
REQ-028 SHALL abandon a sequence when rst is asserted mid-sequence: no further cfg beat after the reset edge, and the partial command is not counted.

Configuration
REQ-029 SHALL, with macro AXIS_CFG_SEQ_GAP_EN defined, include GAP: a down-counter loaded with GAP_CYCLES on the LEN beat; exit to IDLE when it reaches 0; GAP_CYCLES=0 means one GAP cycle.
REQ-030 SHALL, without AXIS_CFG_SEQ_GAP_EN, have no GAP state and no gap counter; the GAP_CYCLES parameter is ignored.

Structure
REQ-031 SHALL place the state encoding (IDLE=0, SEL=1, ADDR=2, LEN=3, GAP=4, 3 bits) and the direction constants DIR_WR=0, DIR_RD=1 in shared package axis_pkg.
REQ-032 SHALL use one sub-module, axis_cfg_seq_gap (gap down-counter), instantiated only when AXIS_CFG_SEQ_GAP_EN is defined.

Verification
REQ-033 SHALL check a single write: cmd dir=0, addr=0x1000_0000, len=0x40 -> beats (1,0), (23,0x1000_0000), (24,0x40) on cycles +1, +2, +3; cmd_count=1.
REQ-034 SHALL check a single read: cmd dir=1, addr=0x2000_0100, len=0x200 -> beats (2,0), (23,0x2000_0100), (24,0x200); cmd_ready low during the beats.
REQ-035 SHALL check a zero-length command: len=0 accepted -> no cfg_valid, cmd_count unchanged, cmd_ready still 1.
REQ-036 SHALL check reset mid-sequence: rst asserted on the ADDR cycle -> no LEN beat, cmd_count=0, busy=0 next cycle.
REQ-037 SHALL check the gap with the macro defined and GAP_CYCLES=4: cmd_valid held high for two commands -> second SEL beat 8 cycles after the first SEL beat.
REQ-038 SHALL check counter wrap: cmd_count preset to 0xFFFF via 65535 commands -> next LEN beat gives 0x0000.
